// File: rtl/pwm_pkg.sv
// Shared PWM definitions used by the generator and the capture path.
package pwm_pkg;

    localparam int unsigned PWM_RESOLUTION = 8;
    localparam int unsigned PWM_CNT_W      = 32;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StHigh,
        StLow
    } pwm_cap_state_t;

endpackage

// File: rtl/pwm_divider.sv
// Sequential restoring divider producing one quotient bit per cycle.
// The caller guarantees dividend_i >> QuotW < divisor_i so the quotient fits in QuotW bits.
module pwm_divider
    import pwm_pkg::*;
#(
    parameter int unsigned DivW  = PWM_CNT_W,
    parameter int unsigned QuotW = PWM_RESOLUTION + 1,
    localparam int unsigned DvdW = DivW + QuotW - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DvdW-1:0]  dividend_i,
    input  logic [DivW-1:0]  divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [QuotW-1:0] quotient_o
);

    localparam int unsigned IterW = (QuotW > 1) ? $clog2(QuotW) : 1;

    logic             busy_q, busy_d;
    logic [IterW-1:0] iter_q, iter_d;
    logic [DivW-1:0]  rem_q, rem_d;
    logic [QuotW-1:0] dvd_q, dvd_d;
    logic [DivW-1:0]  dsr_q, dsr_d;
    logic [QuotW-2:0] quo_q, quo_d;

    logic [DivW:0]    trial;
    logic [DivW:0]    diff;
    logic             q_bit;
    logic             last;
    logic [QuotW-1:0] quo_full;

    always_comb begin
        trial    = {rem_q, dvd_q[QuotW-1]};
        diff     = trial - {1'b0, dsr_q};
        // Remainder stays below the divisor, so the borrow bit alone decides the quotient bit.
        q_bit    = ~diff[DivW];
        last     = busy_q && (iter_q == IterW'(QuotW - 1));
        quo_full = {quo_q, q_bit};

        busy_d = busy_q;
        iter_d = iter_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        quo_d  = quo_q;

        if (abort_i) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            rem_d  = q_bit ? diff[DivW-1:0] : trial[DivW-1:0];
            dvd_d  = dvd_q << 1;
            quo_d  = quo_full[QuotW-2:0];
            iter_d = iter_q + 1'b1;
            busy_d = !last;
        end else if (start_i) begin
            busy_d = 1'b1;
            iter_d = '0;
            rem_d  = {1'b0, dividend_i[DvdW-1:QuotW]};
            dvd_d  = dividend_i[QuotW-1:0];
            dsr_d  = divisor_i;
            quo_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
        end else begin
            busy_q <= busy_d;
            iter_q <= iter_d;
            rem_q  <= rem_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            quo_q  <= quo_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = last && !abort_i;
    assign quotient_o = quo_full;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of a sampled PWM line in clk cycles and
// converts them to a duty code on the generator's 0..2^Resolution scale.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned Resolution = PWM_RESOLUTION,
    parameter int unsigned CntW       = PWM_CNT_W,
    parameter int unsigned Timeout    = 1_250_000,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in_i,
    input  logic                en_i,
    output logic [CntW-1:0]     high_cnt_o,
    output logic [CntW-1:0]     period_cnt_o,
    output logic [Resolution:0] duty_o,
    output logic                meas_valid_o,
    output logic                stuck_o,
    output logic                overrun_o
);

    localparam int unsigned      DutyW    = Resolution + 1;
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);
    localparam logic [CntW-1:0]  CntTmo   = CntW'(Timeout);
    localparam logic [DutyW-1:0] DutyFull = {1'b1, {Resolution{1'b0}}};

    logic [SyncStages-1:0] sync_q;
    logic                  prev_q;
    logic                  s, rise, fall;

    pwm_cap_state_t  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] high_lat_q, high_lat_d;
    logic [CntW-1:0] pend_high_q, pend_high_d;
    logic [CntW-1:0] pend_period_q, pend_period_d;
    logic [CntW-1:0] high_cnt_q, high_cnt_d;
    logic [CntW-1:0] period_cnt_q, period_cnt_d;
    logic [DutyW-1:0] duty_q, duty_d;
    logic            meas_valid_q, meas_valid_d;
    logic            stuck_q, stuck_d;

    logic                 div_start, div_abort, div_busy, div_done;
    logic [DutyW-1:0]     div_quot;
    logic [CntW+Resolution-1:0] div_dividend;
    logic [CntW-1:0]      cnt_inc;
    logic                 timed_out, timeout_hit;

    assign s            = sync_q[SyncStages-1];
    assign rise         = s & ~prev_q;
    assign fall         = ~s & prev_q;
    assign div_abort    = ~en_i;
    assign div_dividend = {high_lat_q, {Resolution{1'b0}}};

    pwm_divider #(
        .DivW  (CntW),
        .QuotW (DutyW)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (div_abort),
        .dividend_i (div_dividend),
        .divisor_i  (cnt_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        high_lat_d    = high_lat_q;
        pend_high_d   = pend_high_q;
        pend_period_d = pend_period_q;
        high_cnt_d    = high_cnt_q;
        period_cnt_d  = period_cnt_q;
        duty_d        = duty_q;
        meas_valid_d  = 1'b0;
        stuck_d       = stuck_q;
        div_start     = 1'b0;
        overrun_o     = 1'b0;
        timeout_hit   = 1'b0;
        cnt_inc       = cnt_q + CntOne;
        timed_out     = cnt_q >= CntTmo;

        if (!en_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            stuck_d = 1'b0;
        end else begin
            if (div_done) begin
                high_cnt_d   = pend_high_q;
                period_cnt_d = pend_period_q;
                duty_d       = div_quot;
                meas_valid_d = 1'b1;
            end

            unique case (state_q)
                StIdle: state_d = StArm;
                StArm: begin
                    if (rise) begin
                        stuck_d = 1'b0;
                        cnt_d   = CntOne;
                        state_d = StHigh;
                    end else if (!stuck_q) begin
                        if (timed_out) timeout_hit = 1'b1;
                        else           cnt_d       = cnt_inc;
                    end
                end
                StHigh: begin
                    if (fall) begin
                        high_lat_d = cnt_q;
                        cnt_d      = cnt_inc;
                        state_d    = StLow;
                    end else if (timed_out) begin
                        timeout_hit = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StLow: begin
                    if (rise) begin
                        cnt_d   = CntOne;
                        state_d = StHigh;
                        // A period closing while the previous division runs is dropped.
                        if (div_busy) begin
                            overrun_o = 1'b1;
                        end else begin
                            div_start     = 1'b1;
                            pend_high_d   = high_lat_q;
                            pend_period_d = cnt_q;
                        end
                    end else if (timed_out) begin
                        timeout_hit = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (timeout_hit) begin
                stuck_d      = 1'b1;
                duty_d       = s ? DutyFull : '0;
                high_cnt_d   = '0;
                period_cnt_d = '0;
                meas_valid_d = 1'b1;
                cnt_d        = CntTmo;
                state_d      = StArm;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q        <= '0;
            prev_q        <= 1'b0;
            state_q       <= StIdle;
            cnt_q         <= '0;
            high_lat_q    <= '0;
            pend_high_q   <= '0;
            pend_period_q <= '0;
            high_cnt_q    <= '0;
            period_cnt_q  <= '0;
            duty_q        <= '0;
            meas_valid_q  <= 1'b0;
            stuck_q       <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SyncStages-2:0], pwm_in_i};
            prev_q        <= s;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            high_lat_q    <= high_lat_d;
            pend_high_q   <= pend_high_d;
            pend_period_q <= pend_period_d;
            high_cnt_q    <= high_cnt_d;
            period_cnt_q  <= period_cnt_d;
            duty_q        <= duty_d;
            meas_valid_q  <= meas_valid_d;
            stuck_q       <= stuck_d;
        end
    end

    assign high_cnt_o   = high_cnt_q;
    assign period_cnt_o = period_cnt_q;
    assign duty_o       = duty_q;
    assign meas_valid_o = meas_valid_q;
    assign stuck_o      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: edge-timestamp reference model, event scoreboard and level checks.
module tb_pwm_capture;

    localparam int unsigned Res      = 8;
    localparam int unsigned CntW     = 32;
    localparam int unsigned Tmo      = 1000;
    localparam int unsigned Sync     = 2;
    localparam int          Lat      = Sync + Res + 2;  // drive cycle to meas_valid cycle
    localparam int          LongHold = 2 * Tmo + 200;

    logic            clk    = 1'b0;
    logic            rst    = 1'b1;
    logic            pwm_in = 1'b0;
    logic            en     = 1'b0;
    logic [CntW-1:0] high_cnt, period_cnt;
    logic [Res:0]    duty;
    logic            meas_valid, stuck, overrun;

    pwm_capture #(
        .Resolution (Res),
        .CntW       (CntW),
        .Timeout    (Tmo),
        .SyncStages (Sync)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in_i     (pwm_in),
        .en_i         (en),
        .high_cnt_o   (high_cnt),
        .period_cnt_o (period_cnt),
        .duty_o       (duty),
        .meas_valid_o (meas_valid),
        .stuck_o      (stuck),
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     t;      // -1: time not checked
        longint hi;
        longint per;
        longint duty;
        longint stuck;
    } meas_t;

    meas_t exp_q[$];
    meas_t obs_q[$];
    int    exp_ovr_q[$];
    int    obs_ovr_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (meas_valid) begin
                meas_t m;
                m.t     = cyc;
                m.hi    = longint'(high_cnt);
                m.per   = longint'(period_cnt);
                m.duty  = longint'(duty);
                m.stuck = longint'(stuck);
                obs_q.push_back(m);
            end
            if (overrun) obs_ovr_q.push_back(cyc);
        end
    end

    // Reference model: works on drive-cycle timestamps of the edges the bench produces.
    bit m_en, m_have_rise, m_have_fall, m_have_start;
    int m_last_rise, m_last_fall, m_last_start;

    task automatic model_rise(input int c);
        if (!m_en) return;
        if (m_have_rise && m_have_fall) begin
            if (m_have_start && (c - m_last_start) <= int'(Res) + 1) begin
                exp_ovr_q.push_back(c + int'(Sync));
            end else begin
                meas_t m;
                m.t     = c + Lat;
                m.hi    = longint'(m_last_fall - m_last_rise);
                m.per   = longint'(c - m_last_rise);
                m.duty  = (m.hi * (longint'(1) << Res)) / m.per;
                m.stuck = 0;
                exp_q.push_back(m);
                m_have_start = 1'b1;
                m_last_start = c;
            end
        end
        m_have_rise = 1'b1;
        m_have_fall = 1'b0;
        m_last_rise = c;
    endtask

    task automatic model_fall(input int c);
        if (m_en && m_have_rise) begin
            m_have_fall = 1'b1;
            m_last_fall = c;
        end
    endtask

    // Drop pending expectations that can no longer appear.
    task automatic cancel(input int keep_res_upto, input int keep_ovr_upto);
        meas_t keep[$];
        int    keep_o[$];
        foreach (exp_q[i]) if (exp_q[i].t <= keep_res_upto) keep.push_back(exp_q[i]);
        foreach (exp_ovr_q[i]) if (exp_ovr_q[i] <= keep_ovr_upto) keep_o.push_back(exp_ovr_q[i]);
        exp_q     = keep;
        exp_ovr_q = keep_o;
        m_have_rise  = 1'b0;
        m_have_fall  = 1'b0;
        m_have_start = 1'b0;
    endtask

    task automatic step(input bit v);
        @(posedge clk);
        #1;
        if (v && !pwm_in) model_rise(cyc);
        else if (!v && pwm_in) model_fall(cyc);
        pwm_in = v;
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic wave(input int h, input int p, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++) step(i < h);
    endtask

    task automatic long_hold(input bit v);
        meas_t m;
        hold(v, LongHold);
        m.t     = -1;
        m.hi    = 0;
        m.per   = 0;
        m.duty  = v ? (longint'(1) << Res) : 0;
        m.stuck = 1;
        exp_q.push_back(m);
        m_have_rise = 1'b0;
        m_have_fall = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, ".high_cnt"}, longint'(high_cnt), 0);
        check_eq({tag, ".period_cnt"}, longint'(period_cnt), 0);
        check_eq({tag, ".duty"}, longint'(duty), 0);
        check_eq({tag, ".meas_valid"}, longint'(meas_valid), 0);
        check_eq({tag, ".stuck"}, longint'(stuck), 0);
        check_eq({tag, ".overrun"}, longint'(overrun), 0);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst  = 1'b0;
        en   = 1'b1;
        m_en = 1'b1;
        hold(0, 3);

        // Steady 25/100.
        wave(25, 100, 4);
        check_eq("steady.high_cnt", longint'(high_cnt), 25);
        check_eq("steady.period_cnt", longint'(period_cnt), 100);
        check_eq("steady.duty", longint'(duty), 64);

        // Half duty, generator-style.
        wave(32, 64, 6);
        check_eq("half.duty", longint'(duty), 128);

        // Line stuck low, then 30/100.
        long_hold(0);
        check_eq("stuck_lo.stuck", longint'(stuck), 1);
        check_eq("stuck_lo.duty", longint'(duty), 0);
        check_eq("stuck_lo.high_cnt", longint'(high_cnt), 0);
        check_eq("stuck_lo.period_cnt", longint'(period_cnt), 0);
        hold(1, 4);
        check_eq("stuck_lo.clear", longint'(stuck), 0);
        hold(1, 26);
        hold(0, 70);
        wave(30, 100, 2);
        check_eq("after_stuck.duty", longint'(duty), 76);

        // Line stuck high.
        long_hold(1);
        check_eq("stuck_hi.stuck", longint'(stuck), 1);
        check_eq("stuck_hi.duty", longint'(duty), 256);
        hold(0, 50);
        wave(40, 100, 3);

        // Short period: every other closing rise overruns.
        begin
            int h5;
            h5 = int'($urandom_range(4, 1));
            wave(h5, 5, 12);
        end
        hold(0, 20);

        // Random waveforms.
        for (int k = 0; k < 40; k++) begin
            int p, h;
            p = int'($urandom_range(150, 2));
            h = int'($urandom_range(p - 1, 1));
            wave(h, p, 1);
        end
        hold(0, 20);

        // en dropped mid-HIGH with a division in flight.
        wave(40, 100, 2);
        hold(1, 5);
        @(posedge clk);
        #1;
        en   = 1'b0;
        m_en = 1'b0;
        cancel(cyc, cyc - 1);
        hold(0, 20);
        check_eq("en_off.stuck", longint'(stuck), 0);
        @(posedge clk);
        #1;
        en   = 1'b1;
        m_en = 1'b1;
        hold(0, 5);
        wave(35, 90, 3);

        // Reset mid-division.
        wave(50, 120, 2);
        hold(1, 6);
        @(posedge clk);
        #1;
        m_en = 1'b0;
        cancel(cyc - 1, cyc - 1);
        rst    = 1'b1;
        pwm_in = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        m_en = 1'b1;
        check_zero_outputs("post_rst");
        hold(0, 5);
        wave(45, 110, 3);
        check_eq("post_rst.high_cnt", longint'(high_cnt), 45);
        check_eq("post_rst.period_cnt", longint'(period_cnt), 110);
        hold(0, 30);

        // Scoreboard.
        check_eq("meas.count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            if (exp_q[i].t >= 0) check_eq($sformatf("meas%0d.t", i), obs_q[i].t, exp_q[i].t);
            check_eq($sformatf("meas%0d.hi", i), obs_q[i].hi, exp_q[i].hi);
            check_eq($sformatf("meas%0d.per", i), obs_q[i].per, exp_q[i].per);
            check_eq($sformatf("meas%0d.duty", i), obs_q[i].duty, exp_q[i].duty);
            check_eq($sformatf("meas%0d.stuck", i), obs_q[i].stuck, exp_q[i].stuck);
        end
        check_eq("ovr.count", obs_ovr_q.size(), exp_ovr_q.size());
        for (int i = 0; i < obs_ovr_q.size() && i < exp_ovr_q.size(); i++)
            check_eq($sformatf("ovr%0d.t", i), obs_ovr_q[i], exp_ovr_q[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
